hs32_irqcond: RTL

HS32_IRQCOND -- requirements
Module: hs32_irqcond

---
 rtl/hs32_irqcond.sv | 110 +++++++++++
 1 files changed

// File: rtl/hs32_irqcond.sv
// Interrupt line conditioner: sync, polarity, edge/level capture, MMIO regs; 1-cycle ack.
// Optional HS32_IRQCOND_DEBOUNCE_EN adds a 4-cycle stability filter per line.
module hs32_irqcond (
  input  logic        clk,
  input  logic        reset,
  input  logic        stb,
  output logic        ack,
  input  logic [31:0] addr,
  input  logic [31:0] dtw,
  output logic [31:0] dtr,
  input  logic        rw,
  input  logic [23:0] irq_in,
  input  logic        int_ack,
  input  logic [4:0]  ack_vec,
  output logic [23:0] interrupts
);

  localparam logic [1:0] REG_MODE = 2'd0;
  localparam logic [1:0] REG_POL  = 2'd1;
  localparam logic [1:0] REG_PEND = 2'd2;
  localparam logic [1:0] REG_RAW  = 2'd3;

  logic [23:0] s1, s2, mode, pol, pend, prev;
  logic [23:0] cond, line, rise, clr, ack_mask, pend_next;
  logic        wr;
  logic        unused_bits;

  assign unused_bits = ^{addr[31:4], addr[1:0], dtw[31:24]};

  assign ack  = stb;
  assign wr   = stb & rw;
  assign cond = s2 ^ pol;

`ifdef HS32_IRQCOND_DEBOUNCE_EN
  logic [23:0][1:0] stab_cnt;
  logic [23:0]      filt;

  // Filtered value flips only after cond disagrees with it for 4 consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stab_cnt <= '0;
      filt     <= '0;
    end else begin
      for (int i = 0; i < 24; i++) begin
        if (cond[i] != filt[i]) begin
          if (stab_cnt[i] == 2'd3) begin
            filt[i]     <= cond[i];
            stab_cnt[i] <= 2'd0;
          end else begin
            stab_cnt[i] <= stab_cnt[i] + 2'd1;
          end
        end else begin
          stab_cnt[i] <= 2'd0;
        end
      end
    end
  end

  assign line = filt;
`else
  assign line = cond;
`endif

  always_comb begin
    ack_mask = '0;
    if (int_ack) begin
      for (int i = 0; i < 24; i++) begin
        if (ack_vec == 5'(i)) ack_mask[i] = 1'b1;
      end
    end
  end

  assign clr  = ack_mask | ((wr && addr[3:2] == REG_PEND) ? dtw[23:0] : 24'd0);
  assign rise = line & ~prev;

  // Edge lines: rise sets and beats any same-cycle clear. Level lines track the line.
  assign pend_next = (mode & ((pend & ~clr) | rise)) | (~mode & line);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= '0;
      s2   <= '0;
      prev <= '0;
      mode <= '0;
      pol  <= '0;
      pend <= '0;
    end else begin
      s1   <= irq_in;
      s2   <= s1;
      prev <= line;
      pend <= pend_next;
      if (wr && addr[3:2] == REG_MODE) mode <= dtw[23:0];
      if (wr && addr[3:2] == REG_POL)  pol  <= dtw[23:0];
    end
  end

  assign interrupts = pend;

  always_comb begin
    dtr = 32'd0;
    case (addr[3:2])
      REG_MODE: dtr = {8'd0, mode};
      REG_POL:  dtr = {8'd0, pol};
      REG_PEND: dtr = {8'd0, pend};
      REG_RAW:  dtr = {8'd0, cond};
      default:  dtr = 32'd0;
    endcase
  end

endmodule
